jtag_axi_dispatch: RTL and testbench

JTAG_AXI_DISPATCH -- requirements
Module: jtag_axi_dispatch

---
 rtl/jtag_axi_pkg.sv | 31 +++
 rtl/jtag_axi_dispatch_if.sv | 29 ++
 rtl/jtag_axi_dispatch_wdt.sv | 37 +++
 rtl/jtag_axi_dispatch.sv | 170 +++++++++++++++++
 tb/tb_jtag_axi_dispatch.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_axi_pkg.sv
// Shared types for the JTAG-to-AXI dispatcher: FSM states, status codes, request control fields.
package jtag_axi_pkg;

  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned CTRL_W  = 1 + SIZE_W;
  localparam int unsigned STALE_W = 4;
  localparam int unsigned DROP_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } disp_state_e;

  typedef enum logic [2:0] {
    STAT_IDLE    = 3'd0,
    STAT_PENDING = 3'd1,
    STAT_OK      = 3'd2,
    STAT_ERR     = 3'd3,
    STAT_TIMEOUT = 3'd4
  } status_code_e;

  // Upper bits of the request payload; address and data follow below it.
  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
  } req_ctrl_t;

endpackage

// File: rtl/jtag_axi_dispatch_if.sv
// Request/response FIFO handshakes between the dispatcher (master) and the async FIFOs (slave).
interface jtag_axi_dispatch_if
  import jtag_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  localparam int unsigned PAY_W = ADDR_W + DATA_W + CTRL_W;

  logic              req_valid_o;
  logic              req_ready_i;
  logic [PAY_W-1:0]  req_payload_o;
  logic              rsp_valid_i;
  logic              rsp_ready_o;
  logic [DATA_W-1:0] rsp_data_i;
  logic [RESP_W-1:0] rsp_resp_i;

  modport master (
    output req_valid_o, req_payload_o, rsp_ready_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_resp_i
  );

  modport slave (
    input  req_valid_o, req_payload_o, rsp_ready_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, rsp_resp_i
  );

endinterface

// File: rtl/jtag_axi_dispatch_wdt.sv
// Response watchdog: counts tck cycles from start; expired rises in the TIMEOUT_CYC-th cycle.
module jtag_axi_dispatch_wdt #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic tck,
  input  logic trstn,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // cnt_q holds (cycles elapsed - 1); expired is registered so it lines up with cycle TIMEOUT_CYC.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      expired <= 1'b0;
    end else if (start) begin
      cnt_q   <= '0;
      run_q   <= 1'b1;
      expired <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      expired <= 1'b0;
    end else if (run_q && !expired) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      expired <= (cnt_q == CNT_W'(TIMEOUT_CYC - 2));
    end
  end

endmodule

// File: rtl/jtag_axi_dispatch.sv
// JTAG-to-AXI dispatcher: hands one request to the request FIFO and records the response as status.
// Response timeout and stale-response tracking are built only with JTAG_AXI_DISPATCH_TIMEOUT_EN defined.
module jtag_axi_dispatch
  import jtag_axi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                tck,
  input  logic                trstn,
  input  logic                req_new_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  input  logic                req_write_i,
  input  logic [SIZE_W-1:0]   req_size_i,
  jtag_axi_dispatch_if.master bus,
  input  logic                status_rd_i,
  output logic [2:0]          status_code_o,
  output logic [DATA_W-1:0]   status_data_o,
  output logic [RESP_W-1:0]   status_resp_o,
  output logic                busy_o,
  output logic [DROP_W-1:0]   drop_cnt_o
);

  if (TIMEOUT_CYC < 2) begin : g_cfg_check
    $error("jtag_axi_dispatch: TIMEOUT_CYC must be at least 2");
  end

  disp_state_e        state_q, state_d;
  req_ctrl_t          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  status_code_e       code_q, code_d;
  logic [DATA_W-1:0]  sdata_q, sdata_d;
  logic [RESP_W-1:0]  sresp_q, sresp_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [STALE_W-1:0] stale_q;
  logic               expired_c;

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      code_q  <= STAT_IDLE;
      sdata_q <= '0;
      sresp_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      code_q  <= code_d;
      sdata_q <= sdata_d;
      sresp_q <= sresp_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Next state and registered-output next values; a start in DONE wins over the status ack.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    code_d  = code_q;
    sdata_d = sdata_q;
    sresp_d = sresp_q;
    drop_d  = drop_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (req_new_i) begin
          ctrl_d  = '{write: req_write_i, size: req_size_i};
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          code_d  = STAT_PENDING;
          state_d = S_ISSUE;
        end else if ((state_q == S_DONE) && status_rd_i) begin
          code_d  = STAT_IDLE;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (valid_q && bus.req_ready_i) begin
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (bus.rsp_valid_i && (stale_q == '0)) begin
          sdata_d = bus.rsp_data_i;
          sresp_d = bus.rsp_resp_i;
          code_d  = (bus.rsp_resp_i == '0) ? STAT_OK : STAT_ERR;
          state_d = S_DONE;
        end else if (expired_c) begin
          code_d  = STAT_TIMEOUT;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (req_new_i && ((state_q == S_ISSUE) || (state_q == S_WAIT_RSP)) && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end

    busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT_RSP);
    valid_d = (state_d == S_ISSUE);
  end

`ifdef JTAG_AXI_DISPATCH_TIMEOUT_EN
  logic [STALE_W-1:0] stale_d;
  logic               capture_c;
  logic               tmo_take_c;
  logic               stale_drop_c;

  jtag_axi_dispatch_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .tck     (tck),
    .trstn   (trstn),
    .start   ((state_q == S_ISSUE) && valid_q && bus.req_ready_i),
    .clear   ((state_q == S_WAIT_RSP) && (state_d != S_WAIT_RSP)),
    .expired (expired_c)
  );

  // Each timeout leaves one response outstanding in the FIFO; the next uncaptured response retires it.
  always_comb begin
    capture_c    = (state_q == S_WAIT_RSP) && bus.rsp_valid_i && (stale_q == '0);
    tmo_take_c   = (state_q == S_WAIT_RSP) && expired_c && !capture_c;
    stale_drop_c = bus.rsp_valid_i && (stale_q != '0);
    stale_d      = stale_q;
    if (tmo_take_c && !stale_drop_c && (stale_q != '1)) begin
      stale_d = stale_q + STALE_W'(1);
    end else if (stale_drop_c && !tmo_take_c) begin
      stale_d = stale_q - STALE_W'(1);
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      stale_q <= '0;
    end else begin
      stale_q <= stale_d;
    end
  end
`else
  assign expired_c = 1'b0;
  assign stale_q   = '0;
`endif

  assign bus.req_valid_o   = valid_q;
  assign bus.req_payload_o = {ctrl_q, addr_q, data_q};
  assign bus.rsp_ready_o   = 1'b1;
  assign status_code_o     = code_q;
  assign status_data_o     = sdata_q;
  assign status_resp_o     = sresp_q;
  assign busy_o            = busy_q;
  assign drop_cnt_o        = drop_q;

endmodule

// File: tb/tb_jtag_axi_dispatch.sv
// Self-checking bench for jtag_axi_dispatch: directed and randomized transactions against a transaction-level model.
module tb_jtag_axi_dispatch;
  import jtag_axi_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAY_W  = ADDR_W + DATA_W + 4;
`ifdef JTAG_AXI_DISPATCH_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic              tck         = 1'b0;
  logic              trstn       = 1'b0;
  logic              req_new_i   = 1'b0;
  logic [ADDR_W-1:0] req_addr_i  = '0;
  logic [DATA_W-1:0] req_data_i  = '0;
  logic              req_write_i = 1'b0;
  logic [2:0]        req_size_i  = '0;
  logic              status_rd_i = 1'b0;
  logic [2:0]        status_code_o;
  logic [DATA_W-1:0] status_data_o;
  logic [1:0]        status_resp_o;
  logic              busy_o;
  logic [7:0]        drop_cnt_o;

  jtag_axi_dispatch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  jtag_axi_dispatch #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .tck           (tck),
    .trstn         (trstn),
    .req_new_i     (req_new_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_write_i   (req_write_i),
    .req_size_i    (req_size_i),
    .bus           (bus.master),
    .status_rd_i   (status_rd_i),
    .status_code_o (status_code_o),
    .status_data_o (status_data_o),
    .status_resp_o (status_resp_o),
    .busy_o        (busy_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of what the status/request outputs must show.
  int                exp_drop  = 0;
  logic [2:0]        exp_code  = 3'd0;
  logic [DATA_W-1:0] exp_sdata = '0;
  logic [1:0]        exp_sresp = '0;
  logic [PAY_W-1:0]  exp_pay   = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit exp_valid, input bit exp_busy);
    check({tag, ".req_valid"}, 128'(bus.req_valid_o), 128'(exp_valid));
    check({tag, ".payload"},   128'(bus.req_payload_o), 128'(exp_pay));
    check({tag, ".rsp_ready"}, 128'(bus.rsp_ready_o), 128'(1'b1));
    check({tag, ".code"},      128'(status_code_o), 128'(exp_code));
    check({tag, ".sdata"},     128'(status_data_o), 128'(exp_sdata));
    check({tag, ".sresp"},     128'(status_resp_o), 128'(exp_sresp));
    check({tag, ".busy"},      128'(busy_o), 128'(exp_busy));
    check({tag, ".drop"},      128'(drop_cnt_o), 128'(exp_drop));
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic bump_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic start_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input bit w, input logic [2:0] sz, input bit with_rd);
    req_new_i   = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_write_i = w;
    req_size_i  = sz;
    status_rd_i = with_rd;
    tick();
    req_new_i   = 1'b0;
    status_rd_i = 1'b0;
    exp_pay     = {w, sz, a, d};
    exp_code    = 3'd1;
    check_outs("start", 1'b1, 1'b1);
  endtask

  task automatic accept(input int dly);
    bus.req_ready_i = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      check_outs("issue_hold", 1'b1, 1'b1);
    end
    bus.req_ready_i = 1'b1;
    tick();
    bus.req_ready_i = 1'b0;
    check_outs("accepted", 1'b0, 1'b1);
  endtask

  task automatic respond(input int dly, input logic [DATA_W-1:0] rd, input logic [1:0] resp);
    for (int i = 0; i < dly; i++) begin
      tick();
      check_outs("wait_rsp", 1'b0, 1'b1);
    end
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i  = rd;
    bus.rsp_resp_i  = resp;
    tick();
    bus.rsp_valid_i = 1'b0;
    exp_sdata = rd;
    exp_sresp = resp;
    exp_code  = (resp == 2'd0) ? 3'd2 : 3'd3;
    check_outs("done", 1'b0, 1'b0);
  endtask

  task automatic ack();
    status_rd_i = 1'b1;
    tick();
    status_rd_i = 1'b0;
    exp_code = 3'd0;
    check_outs("ack", 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_drop  = 0;
    exp_code  = 3'd0;
    exp_sdata = '0;
    exp_sresp = '0;
    exp_pay   = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                chain;

    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_data_i  = '0;
    bus.rsp_resp_i  = '0;

    // Reset state
    #3;
    check_outs("reset", 1'b0, 1'b0);
    @(posedge tck);
    #1 trstn = 1'b1;
    tick();
    check_outs("post_reset", 1'b0, 1'b0);

    // Directed write, ready after 3 cycles, OKAY response, then ack
    start_txn(32'h1000_0000, 32'hDEAD_BEEF, 1'b1, 3'd2, 1'b0);
    check("write.payload_exact", 128'(bus.req_payload_o), 128'({1'b1, 3'd2, 32'h1000_0000, 32'hDEAD_BEEF}));
    accept(3);
    respond(1, 32'h0, 2'd0);
    check("write.code_ok", 128'(status_code_o), 128'(3'd2));
    ack();

    // Directed read with SLVERR
    start_txn(32'h2000_0040, 32'h0, 1'b0, 3'd2, 1'b0);
    accept(0);
    respond(2, 32'hCAFE_F00D, 2'd2);
    check("read.code_err", 128'(status_code_o), 128'(3'd3));
    check("read.sdata", 128'(status_data_o), 128'(32'hCAFE_F00D));
    ack();
    check("read.sdata_kept", 128'(status_data_o), 128'(32'hCAFE_F00D));

    // Randomized back-to-back transactions; some restart straight from DONE with a simultaneous ack
    for (int i = 0; i < 10; i++) begin
      chain = (i > 0) && ($urandom_range(0, 1) == 1);
      if (i > 0 && !chain) ack();
      a = $urandom();
      d = $urandom();
      start_txn(a, d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), chain);
      accept(int'($urandom_range(0, 3)));
      respond(int'($urandom_range(0, 3)), $urandom(), 2'($urandom_range(0, 3)));
    end
    ack();

    // Drops while a transaction is outstanding, then saturation
    start_txn(32'hA5A5_0000, 32'h1234_5678, 1'b1, 3'd1, 1'b0);
    req_new_i = 1'b1;
    req_addr_i = $urandom();
    tick();
    req_new_i = 1'b0;
    bump_drop();
    check_outs("drop_in_issue", 1'b1, 1'b1);
    accept(1);
    for (int i = 0; i < 3; i++) begin
      req_new_i  = 1'b1;
      req_addr_i = $urandom();
      req_data_i = $urandom();
      tick();
      req_new_i = 1'b0;
      bump_drop();
      check_outs("drop_in_wait", 1'b0, 1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      req_new_i = 1'b1;
      tick();
      req_new_i = 1'b0;
      bump_drop();
      tick();
    end
    check_outs("drop_saturate", 1'b0, 1'b1);
    check("drop.is_255", 128'(drop_cnt_o), 128'(8'd255));
    respond(0, 32'h5555_AAAA, 2'd0);
    ack();

`ifdef JTAG_AXI_DISPATCH_TIMEOUT_EN
    // No response: TIMEOUT after exactly TMO cycles in WAIT_RSP
    start_txn(32'h3000_0000, 32'h0, 1'b0, 3'd2, 1'b0);
    accept(0);
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    check_outs("tmo_not_yet", 1'b0, 1'b1);
    tick();
    exp_code = 3'd4;
    check_outs("tmo_fire", 1'b0, 1'b0);
    // New transaction; the late response to the timed-out one must be discarded
    start_txn(32'h3000_0004, 32'h0, 1'b0, 3'd2, 1'b0);
    accept(1);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i  = 32'h0BAD_0BAD;
    bus.rsp_resp_i  = 2'd1;
    tick();
    bus.rsp_valid_i = 1'b0;
    check_outs("stale_discard", 1'b0, 1'b1);
    respond(2, 32'h600D_D47A, 2'd0);
    ack();
`else
    // Without the timeout feature WAIT_RSP waits indefinitely
    start_txn(32'h3000_0000, 32'h0, 1'b0, 3'd2, 1'b0);
    accept(0);
    for (int i = 0; i < 1100; i++) tick();
    check_outs("no_timeout", 1'b0, 1'b1);
    respond(0, 32'h600D_D47A, 2'd0);
    ack();
`endif

    // Reset mid-transaction, observed before the next clock edge
    start_txn(32'h4000_0000, 32'h9999_0000, 1'b1, 3'd2, 1'b0);
    accept(0);
    #2 trstn = 1'b0;
    #1;
    model_reset();
    check_outs("rst_async", 1'b0, 1'b0);
    tick();
    tick();
    check_outs("rst_held", 1'b0, 1'b0);
    trstn = 1'b1;
    tick();
    tick();
    check_outs("rst_released", 1'b0, 1'b0);
    start_txn(32'h4000_0010, 32'h7777_8888, 1'b1, 3'd2, 1'b0);
    accept(2);
    respond(1, 32'h0, 2'd0);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
